// File: rtl/mealy_seq_pkg.sv
// mealy_seq_pkg: definitions shared by the sequence detector.
//   state_t   - detector FSM states (IDLE / FILL / HUNT)
//   clamp_len - maps a requested pattern length onto the range 1..max_len
package mealy_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,  // detector disabled, history empty
        FILL = 2'd1,  // collecting the first len-1 bits
        HUNT = 2'd2   // history full, every valid bit is compared
    } state_t;

    // Zero becomes 1 and anything above max_len becomes max_len.
    function automatic int unsigned clamp_len(input int unsigned len,
                                              input int unsigned max_len);
        if (len == 0)
            return 1;
        else if (len > max_len)
            return max_len;
        else
            return len;
    endfunction

endpackage

// File: rtl/mealy_seq_detector_sat_counter.sv
// sat_counter: saturating event counter with a sticky overflow flag.
//   clk, rst_n - clock and asynchronous active-low reset
//   inc        - count one event this cycle
//   clr        - synchronous clear of cnt and sat; wins over inc
//   cnt        - event count, holds at all-ones
//   sat        - set by an event that arrives while cnt is all-ones
module sat_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt,
    output logic             sat
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            sat <= 1'b0;
        end else if (clr) begin
            cnt <= '0;
            sat <= 1'b0;
        end else if (inc) begin
            if (&cnt)
                sat <= 1'b1;
            else
                cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/mealy_seq_detector.sv
// mealy_seq_detector: configurable serial pattern detector with a Mealy
// match output and a saturating match counter.
//   clk, rst_n   - clock, asynchronous active-low reset
//   en           - enable; dropping it returns to IDLE and clears history
//   cfg_load     - latch cfg_pattern/cfg_len/cfg_overlap (only IDLE, en=0)
//   cfg_pattern  - pattern, bit [len-1] oldest, bit [0] newest
//   cfg_len      - pattern length, clamped to 1..MAX_LEN
//   cfg_overlap  - 1: overlapping matches, 0: restart after each match
//   in_valid     - in_bit is valid this cycle
//   in_bit       - serial input
//   cnt_clr      - clear match_cnt and cnt_sat
//   match        - combinational match for the current in_bit
//   match_cnt    - saturating match count
//   cnt_sat      - sticky saturation flag
module mealy_seq_detector
    import mealy_seq_pkg::*;
#(
    parameter int                 MAX_LEN = 8,
    parameter int                 CNT_W   = 8,
    parameter logic [MAX_LEN-1:0] PAT_RST = MAX_LEN'(8'b0000_0001)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       en,
    input  logic                       cfg_load,
    input  logic [MAX_LEN-1:0]         cfg_pattern,
    input  logic [$clog2(MAX_LEN)+1-1:0] cfg_len,
    input  logic                       cfg_overlap,
    input  logic                       in_valid,
    input  logic                       in_bit,
    input  logic                       cnt_clr,
    output logic                       match,
    output logic [CNT_W-1:0]           match_cnt,
    output logic                       cnt_sat
);

    localparam int LEN_W = $clog2(MAX_LEN) + 1;

    state_t             state, state_nx;
    logic [MAX_LEN-1:0] hist, hist_nx;
    logic [LEN_W-1:0]   fill_cnt, fill_nx;

    logic [MAX_LEN-1:0] pattern;
    logic [LEN_W-1:0]   len;
    logic               overlap;

    logic [MAX_LEN-1:0] len_mask;
    logic [MAX_LEN-1:0] window;
    logic               len_one;
    logic               cfg_ok;

    // Only the low len bits of the window take part in the compare.
    always_comb begin
        len_mask = '0;
        for (int i = 0; i < MAX_LEN; i++)
            len_mask[i] = (i < int'(len));
    end

    assign window  = {hist[MAX_LEN-2:0], in_bit};
    assign len_one = (len == LEN_W'(1));
    assign cfg_ok  = cfg_load & ~en & (state == IDLE);

    always_comb begin
        state_nx = state;
        hist_nx  = hist;
        fill_nx  = fill_cnt;
        match    = 1'b0;
        case (state)
            IDLE: begin
                // A one-bit pattern needs no history, so compare at once.
                if (en)
                    state_nx = len_one ? HUNT : FILL;
            end
            FILL: begin
                if (in_valid) begin
                    hist_nx = window;
                    fill_nx = fill_cnt + 1'b1;
                    if (fill_nx == len - 1'b1)
                        state_nx = HUNT;
                end
            end
            HUNT: begin
                if (in_valid) begin
                    match   = ((window ^ pattern) & len_mask) == '0;
                    hist_nx = window;
                    if (match && !overlap) begin
                        hist_nx  = '0;
                        fill_nx  = '0;
                        state_nx = len_one ? HUNT : FILL;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
        // Disable overrides everything, including a same-cycle match.
        if (!en) begin
            state_nx = IDLE;
            hist_nx  = '0;
            fill_nx  = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            hist     <= '0;
            fill_cnt <= '0;
        end else begin
            state    <= state_nx;
            hist     <= hist_nx;
            fill_cnt <= fill_nx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pattern <= PAT_RST;
            len     <= LEN_W'(MAX_LEN);
            overlap <= 1'b1;
        end else if (cfg_ok) begin
            pattern <= cfg_pattern;
            len     <= LEN_W'(clamp_len(32'(cfg_len), MAX_LEN));
            overlap <= cfg_overlap;
        end
    end

    sat_counter #(.CNT_W(CNT_W)) u_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (match),
        .clr   (cnt_clr),
        .cnt   (match_cnt),
        .sat   (cnt_sat)
    );

endmodule

// File: tb/tb_mealy_seq_detector.sv
// Bench for mealy_seq_detector: directed scenarios plus a randomized run
// checked against a queue-based model of the detector's behaviour. Two
// instances share stimulus: an 8-bit counter and a 2-bit counter.
module tb_mealy_seq_detector;

    logic       clk = 1'b0;
    logic       rst_n, en, cfg_load, cfg_overlap, in_valid, in_bit, cnt_clr;
    logic [7:0] cfg_pattern;
    logic [3:0] cfg_len;
    logic       match, cnt_sat, match2, sat2;
    logic [7:0] match_cnt;
    logic [1:0] cnt2;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mealy_seq_detector dut (
        .clk(clk), .rst_n(rst_n), .en(en), .cfg_load(cfg_load),
        .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
        .in_valid(in_valid), .in_bit(in_bit), .cnt_clr(cnt_clr),
        .match(match), .match_cnt(match_cnt), .cnt_sat(cnt_sat)
    );

    mealy_seq_detector #(.CNT_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .en(en), .cfg_load(cfg_load),
        .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
        .in_valid(in_valid), .in_bit(in_bit), .cnt_clr(cnt_clr),
        .match(match2), .match_cnt(cnt2), .cnt_sat(sat2)
    );

    // ---------------- reference model ----------------
    // "active" means enabled at the previous edge; m_bits holds valid bits
    // received since the detector last started (en rise or non-overlap hit).
    logic       m_active;
    bit         m_bits[$];
    logic [7:0] m_pat;
    int         m_len;
    logic       m_ovl;
    int         m_cnt8, m_cnt2;
    logic       m_sat8, m_sat2;

    logic obs_match, obs_match2, exp_match;

    function automatic void model_reset();
        m_active = 1'b0;
        m_bits.delete();
        m_pat  = 8'h01;
        m_len  = 8;
        m_ovl  = 1'b1;
        m_cnt8 = 0; m_cnt2 = 0;
        m_sat8 = 1'b0; m_sat2 = 1'b0;
    endfunction

    // Last m_len bits (m_len-1 stored plus the current one) equal pattern.
    function automatic logic model_match();
        if (!m_active || !in_valid) return 1'b0;
        if (m_bits.size() < m_len - 1) return 1'b0;
        if (in_bit != m_pat[0]) return 1'b0;
        for (int k = 1; k < m_len; k++)
            if (m_bits[m_bits.size() - k] != m_pat[k]) return 1'b0;
        return 1'b1;
    endfunction

    function automatic void model_update();
        logic mt;
        int   l;
        mt = model_match();
        if (cnt_clr) begin
            m_cnt8 = 0; m_cnt2 = 0; m_sat8 = 1'b0; m_sat2 = 1'b0;
        end else if (mt) begin
            if (m_cnt8 == 255) m_sat8 = 1'b1; else m_cnt8++;
            if (m_cnt2 == 3)   m_sat2 = 1'b1; else m_cnt2++;
        end
        if (!m_active) begin
            if (en) m_active = 1'b1;
            else if (cfg_load) begin
                l = int'(cfg_len);
                m_len = (l == 0) ? 1 : (l > 8) ? 8 : l;
                m_pat = cfg_pattern;
                m_ovl = cfg_overlap;
            end
        end else if (!en) begin
            m_active = 1'b0;
            m_bits.delete();
        end else if (in_valid) begin
            if (mt && !m_ovl) m_bits.delete();
            else begin
                m_bits.push_back(in_bit);
                if (m_bits.size() > 8) void'(m_bits.pop_front());
            end
        end
    endfunction

    // One clock: sample match mid-cycle, advance the model on the edge.
    task automatic tick();
        @(negedge clk);
        obs_match  = match;
        obs_match2 = match2;
        exp_match  = model_match();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic send(input logic b);
        in_valid = 1'b1;
        in_bit   = b;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic load_cfg(input logic [7:0] pat, input logic [3:0] len,
                            input logic ovl);
        en = 1'b0; in_valid = 1'b0; cfg_load = 1'b0;
        tick();
        cfg_pattern = pat; cfg_len = len; cfg_overlap = ovl; cfg_load = 1'b1;
        tick();
        cfg_load = 1'b0; cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0; en = 1'b1;
        tick();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        logic s[8] = '{0, 0, 0, 0, 0, 0, 0, 1};
        en = 1'b1; in_valid = 1'b1; in_bit = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (match !== 1'b0 || match2 !== 1'b0) begin
            errors++; $display("FAIL reset_match: got %b/%b want 0", match, match2);
        end
        checks++;
        if (match_cnt !== 8'd0 || cnt_sat !== 1'b0 || cnt2 !== 2'd0 || sat2 !== 1'b0) begin
            errors++;
            $display("FAIL reset_cnt: got %0d/%b %0d/%b want 0", match_cnt, cnt_sat, cnt2, sat2);
        end
        @(posedge clk); #1;
        rst_n = 1'b1; en = 1'b0; in_valid = 1'b0;
        model_reset();
        // Reset config: pattern 0000_0001, length 8, only the 8th bit hits.
        en = 1'b1;
        tick();
        for (int i = 0; i < 8; i++) begin
            send(s[i]);
            checks++;
            if (obs_match !== (i == 7)) begin
                errors++; $display("FAIL reset_cfg bit%0d: got %b want %b", i, obs_match, i == 7);
            end
        end
    endtask

    task automatic run_1011(input logic ovl, input string name);
        logic s[7] = '{1, 0, 1, 1, 0, 1, 1};
        logic e1[7] = '{0, 0, 0, 1, 0, 0, 1};
        logic e0[7] = '{0, 0, 0, 1, 0, 0, 0};
        load_cfg(8'b0000_1011, 4'd4, ovl);
        for (int i = 0; i < 7; i++) begin
            send(s[i]);
            checks++;
            if (obs_match !== (ovl ? e1[i] : e0[i])) begin
                errors++;
                $display("FAIL %s bit%0d: got %b want %b", name, i + 1, obs_match, ovl ? e1[i] : e0[i]);
            end
        end
        checks++;
        if (match_cnt !== (ovl ? 8'd2 : 8'd1)) begin
            errors++; $display("FAIL %s_cnt: got %0d want %0d", name, match_cnt, ovl ? 2 : 1);
        end
    endtask

    task automatic test_overlap();    run_1011(1'b1, "overlap");    endtask
    task automatic test_nonoverlap(); run_1011(1'b0, "nonoverlap"); endtask

    task automatic test_gap();
        load_cfg(8'b0000_1011, 4'd4, 1'b1);
        send(1'b1);
        send(1'b0);
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b0; in_bit = 1'b1;
            tick();
            checks++;
            if (obs_match !== 1'b0) begin
                errors++; $display("FAIL gap_idle%0d: got %b want 0", i, obs_match);
            end
        end
        send(1'b1);
        checks++;
        if (obs_match !== 1'b0) begin
            errors++; $display("FAIL gap_bit3: got %b want 0", obs_match);
        end
        send(1'b1);
        checks++;
        if (obs_match !== 1'b1) begin
            errors++; $display("FAIL gap_bit4: got %b want 1", obs_match);
        end
    endtask

    task automatic test_cfg_guard();
        logic s[4] = '{1, 0, 1, 1};
        cfg_pattern = 8'h00; cfg_len = 4'd4; cfg_overlap = 1'b0; cfg_load = 1'b1;
        tick();
        cfg_load = 1'b0;
        for (int i = 0; i < 4; i++) begin
            send(s[i]);
            checks++;
            if (obs_match !== (i == 3)) begin
                errors++; $display("FAIL cfg_guard bit%0d: got %b want %b", i, obs_match, i == 3);
            end
        end
    endtask

    task automatic test_saturation();
        load_cfg(8'h01, 4'd1, 1'b1);
        for (int i = 0; i < 5; i++) begin
            send(1'b1);
            checks++;
            if (obs_match !== 1'b1) begin
                errors++; $display("FAIL sat_match%0d: got %b want 1", i, obs_match);
            end
        end
        // Counters must survive an en toggle and a config load.
        en = 1'b0; tick();
        cfg_load = 1'b1; tick(); cfg_load = 1'b0;
        en = 1'b1; tick();
        checks++;
        if (match_cnt !== 8'd5 || cnt_sat !== 1'b0) begin
            errors++; $display("FAIL sat_cnt8: got %0d/%b want 5/0", match_cnt, cnt_sat);
        end
        checks++;
        if (cnt2 !== 2'd3 || sat2 !== 1'b1) begin
            errors++; $display("FAIL sat_cnt2: got %0d/%b want 3/1", cnt2, sat2);
        end
        cnt_clr = 1'b1;
        send(1'b1);
        cnt_clr = 1'b0;
        checks++;
        if (obs_match !== 1'b1 || cnt2 !== 2'd0 || sat2 !== 1'b0 || match_cnt !== 8'd0) begin
            errors++;
            $display("FAIL sat_clr: got m=%b %0d/%b %0d want m=1 0/0 0", obs_match, cnt2, sat2, match_cnt);
        end
    endtask

    task automatic test_reset_midrun();
        logic s[5] = '{1, 1, 0, 1, 1};
        // Default-like config, partial history, reset with en held high.
        load_cfg(8'h01, 4'd8, 1'b1);
        repeat (5) send(1'b0);
        rst_n = 1'b0; #1;
        checks++;
        if (match !== 1'b0 || match_cnt !== 8'd0) begin
            errors++; $display("FAIL rst_mid_async: got %b/%0d want 0/0", match, match_cnt);
        end
        #1 rst_n = 1'b1;
        model_reset();
        tick();
        for (int i = 0; i < 3; i++) begin
            send(i == 2);
            checks++;
            if (obs_match !== 1'b0) begin
                errors++; $display("FAIL rst_mid_hist bit%0d: got %b want 0", i, obs_match);
            end
        end
        load_cfg(8'b0000_1011, 4'd4, 1'b1);
        send(1'b1); send(1'b0); send(1'b1);
        rst_n = 1'b0; #2 rst_n = 1'b1;
        model_reset();
        load_cfg(8'b0000_1011, 4'd4, 1'b1);
        for (int i = 0; i < 5; i++) begin
            send(s[i]);
            checks++;
            if (obs_match !== (i == 4)) begin
                errors++; $display("FAIL rst_mid bit%0d: got %b want %b", i, obs_match, i == 4);
            end
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 3000; n++) begin
            en          = ($urandom_range(0, 24) != 0);
            cfg_load    = ($urandom_range(0, 3) == 0);
            cfg_pattern = 8'($urandom());
            cfg_len     = ($urandom_range(0, 3) != 0) ? 4'($urandom_range(0, 4))
                                                      : 4'($urandom_range(0, 15));
            cfg_overlap = 1'($urandom());
            in_valid    = ($urandom_range(0, 3) != 0);
            in_bit      = 1'($urandom());
            cnt_clr     = ($urandom_range(0, 63) == 0);
            tick();
            checks++;
            if (obs_match !== exp_match || obs_match2 !== exp_match) begin
                errors++; $display("FAIL rand_match n=%0d: got %b/%b want %b", n, obs_match, obs_match2, exp_match);
            end
            checks++;
            if (match_cnt !== 8'(m_cnt8) || cnt_sat !== m_sat8 ||
                cnt2 !== 2'(m_cnt2) || sat2 !== m_sat2) begin
                errors++;
                $display("FAIL rand_cnt n=%0d: got %0d/%b %0d/%b want %0d/%b %0d/%b",
                         n, match_cnt, cnt_sat, cnt2, sat2, m_cnt8, m_sat8, m_cnt2, m_sat2);
            end
        end
        cnt_clr = 1'b0; cfg_load = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0; en = 1'b0; cfg_load = 1'b0; cfg_overlap = 1'b1;
        cfg_pattern = 8'h00; cfg_len = 4'd0; in_valid = 1'b0; in_bit = 1'b0;
        cnt_clr = 1'b0;
        model_reset();
        test_reset();
        test_overlap();
        test_nonoverlap();
        test_gap();
        test_cfg_guard();
        test_saturation();
        test_reset_midrun();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mealy_seq_detector.md
MEALY_SEQ_DETECTOR -- requirements
Module: mealy_seq_detector

Interface
REQ-001 The block SHALL have these parameters, one per line (name, default, meaning):
- MAX_LEN, 8: maximum pattern length in bits.
- CNT_W, 8: match counter width.
- PAT_RST, 8'b0000_0001: reset pattern value (MAX_LEN bits).
REQ-002 The block SHALL have one clock; reset is asynchronous and active-low. Ports, one per line (name, direction, width, meaning):
- clk, in, 1: clock, rising edge.
- rst_n, in, 1: asynchronous active-low reset.
- en, in, 1: detector enable.
- cfg_load, in, 1: load pattern configuration.
- cfg_pattern, in, MAX_LEN: pattern; bit [len-1] is the oldest bit, bit [0] the newest.
- cfg_len, in, $clog2(MAX_LEN)+1: pattern length.
- cfg_overlap, in, 1: 1 = overlapping matches, 0 = non-overlapping.
- in_valid, in, 1: in_bit is valid this cycle.
- in_bit, in, 1: serial input bit.
- cnt_clr, in, 1: synchronous clear of the counter and the sticky flag.
- match, out, 1: Mealy match output.
- match_cnt, out, CNT_W: saturating match count.
- cnt_sat, out, 1: sticky saturation flag.

Function
REQ-003 The FSM SHALL have three states: IDLE (disabled), FILL (history holds fewer than len-1 valid bits), HUNT (history full, compare active).
REQ-004 Next state and match SHALL both be functions of the current state and the inputs (Mealy): match = (state==HUNT) & in_valid & ({hist[len-2:0], in_bit} == pattern[len-1:0]); match SHALL be combinational, with no register delay.
REQ-005 IDLE -> FILL when en=1, or IDLE -> HUNT when en=1 and len==1; any state -> IDLE on the cycle after en=0, clearing hist and fill_cnt.
REQ-006 In FILL, each in_valid cycle SHALL shift in_bit into hist and increment fill_cnt; on reaching len-1 the FSM SHALL transition to HUNT.
REQ-007 Cycles with in_valid=0 SHALL leave state, hist and fill_cnt unchanged and SHALL hold match=0.
REQ-008 In HUNT with in_valid=1, in_bit SHALL shift into hist. On match with overlap=1, the FSM SHALL stay in HUNT. On match with overlap=0, the FSM SHALL clear hist and fill_cnt and go to FILL (HUNT if len==1).
REQ-009 cfg_load SHALL be accepted only in IDLE with en=0; it latches cfg_pattern, the clamped cfg_len and cfg_overlap. cfg_load SHALL be ignored in any other cycle.
REQ-010 Length clamp SHALL map cfg_len==0 to 1 and cfg_len>MAX_LEN to MAX_LEN; pattern bits above len-1 SHALL be ignored.
REQ-011 match_cnt SHALL increment by 1 on each match cycle and saturate at 2^CNT_W-1. cnt_sat SHALL set on a match while the count is already saturated, and stay set until cnt_clr.
REQ-012 When cnt_clr coincides with a match, cnt_clr SHALL win: the counter goes to 0 and cnt_sat to 0.
REQ-013 match_cnt and cnt_sat SHALL be retained across en toggles and cfg_load.

Reset
REQ-014 rst_n=0 SHALL asynchronously force: state=IDLE, hist=0, fill_cnt=0, pattern=PAT_RST, len=MAX_LEN, overlap=1, match_cnt=0, cnt_sat=0.
REQ-015 While rst_n=0, match SHALL be 0 (follows from state=IDLE).
REQ-016 Reset asserted mid-FILL or mid-HUNT SHALL discard partial history; the first post-reset match SHALL require a full len bits after en.

Structure
REQ-017 A shared package mealy_seq_pkg SHALL hold the state enum (IDLE, FILL, HUNT) and the length-clamp function.
REQ-018 The counter and sticky flag SHALL be a sub-module, sat_counter, parameterised by CNT_W, with inc, clr, cnt and sat ports.
REQ-019 The state register SHALL be one always_ff block; next-state and match logic SHALL be one always_comb block with defaults assigned before the case.

Verification (MAX_LEN=8 unless stated)
REQ-020 Overlap scenario: load pattern=4'b1011, len=4, overlap=1, en=1; stream 1,0,1,1,0,1,1 -> match high on bits 4 and 7 only, match_cnt=2.
REQ-021 Non-overlap scenario: same stream with overlap=0 -> match high on bit 4 only, match_cnt=1.
REQ-022 Gap scenario: stream 1,0,(in_valid=0 for 3 cycles),1,1 -> match high only in the cycle of the 4th valid bit; match=0 during the gap cycles.
REQ-023 Config guard: cfg_load with en=1, pattern=4'b0000 -> stored pattern unchanged; the next 1011 still matches.
REQ-024 Saturation: CNT_W=2, len=1, pattern=1, stream of five 1s -> match_cnt=3, cnt_sat=1; then cnt_clr together with a match -> match_cnt=0, cnt_sat=0.
REQ-025 Reset mid-run: after 1,0,1 in FILL, pulse rst_n low, then en=1 and stream 1 -> no match; a full 1011 afterwards -> match.
